// File: rtl/echo_tof_extract.sv
// echo_tof_extract
// Scans a captured 400-sample echo window one bit per clock. It finds runs of
// set bits that are at least MIN_WIDTH long, ignoring the first BLANK_BITS
// samples. It reports the first qualified run, the number of qualified runs
// (saturating at 15) and the number of set bits after blanking.
// Timing: strobe accepted at edge E0, bit k-1 processed at edge E0+k, and the
// results are registered at edge E0+401 together with result_valid.

module echo_tof_extract #(
    parameter int MIN_WIDTH  = 3,
    parameter int BLANK_BITS = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [399:0] total_data,
    input  logic         tola_en,
    output logic         busy,
    output logic         result_valid,
    output logic [8:0]   tof_index,
    output logic [8:0]   pulse_width,
    output logic [3:0]   echo_count,
    output logic [8:0]   ones_total,
    output logic         no_echo,
    output logic         overrun
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SCAN   = 2'd1;
    localparam logic [1:0] S_FINISH = 2'd2;

    localparam logic [8:0] LAST_IDX = 9'd399;
    localparam logic [8:0] MIN_W    = 9'(MIN_WIDTH);
    localparam logic [8:0] BLANK    = 9'(BLANK_BITS);
    localparam logic [3:0] CNT_MAX  = 4'd15;

    logic [1:0]   r_state;
    logic [1:0]   w_state_nxt;

    logic [399:0] r_shadow;
    logic [8:0]   r_idx;
    logic [8:0]   r_run_len;
    logic [8:0]   r_run_start;
    logic         r_first_found;
    logic [8:0]   r_first_start;
    logic [8:0]   r_first_width;
    logic [3:0]   r_count;
    logic [8:0]   r_ones_acc;

    logic         r_result_valid;
    logic [8:0]   r_tof_index;
    logic [8:0]   r_pulse_width;
    logic [3:0]   r_echo_count;
    logic [8:0]   r_ones_total;
    logic         r_no_echo;
    logic         r_overrun;

    logic         w_busy;
    logic         w_bit;
    logic         w_close;
    logic         w_qual;
    logic         w_take_first;
    logic [3:0]   w_count_nxt;
    logic [8:0]   w_first_start_nxt;
    logic [8:0]   w_first_width_nxt;
    logic         w_first_found_nxt;

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next-state decode: a window takes 400 SCAN cycles plus one FINISH cycle.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (tola_en) begin
                    w_state_nxt = S_SCAN;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_SCAN: begin
                if (r_idx == LAST_IDX) begin
                    w_state_nxt = S_FINISH;
                end else begin
                    w_state_nxt = S_SCAN;
                end
            end
            S_FINISH: w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    // FSM output decode: busy covers both SCAN and FINISH.
    always_comb begin
        w_busy = 1'b0;
        case (r_state)
            S_IDLE:   w_busy = 1'b0;
            S_SCAN:   w_busy = 1'b1;
            S_FINISH: w_busy = 1'b1;
            default:  w_busy = 1'b0;
        endcase
    end

    // Run-closing logic: a run closes on a 0 bit in SCAN or unconditionally in FINISH.
    always_comb begin
        w_bit             = r_shadow[0] & (r_idx >= BLANK);
        w_close           = 1'b0;
        w_qual            = 1'b0;
        w_take_first      = 1'b0;
        w_count_nxt       = r_count;
        w_first_start_nxt = r_first_start;
        w_first_width_nxt = r_first_width;
        w_first_found_nxt = r_first_found;
        if (r_state == S_SCAN) begin
            w_close = (r_run_len != 9'd0) & ~w_bit;
        end else if (r_state == S_FINISH) begin
            w_close = (r_run_len != 9'd0);
        end else begin
            w_close = 1'b0;
        end
        w_qual       = w_close & (r_run_len >= MIN_W);
        w_take_first = w_qual & ~r_first_found;
        if (w_qual && (r_count != CNT_MAX)) begin
            w_count_nxt = r_count + 4'd1;
        end else begin
            w_count_nxt = r_count;
        end
        if (w_take_first) begin
            w_first_start_nxt = r_run_start;
            w_first_width_nxt = r_run_len;
            w_first_found_nxt = 1'b1;
        end else begin
            w_first_start_nxt = r_first_start;
            w_first_width_nxt = r_first_width;
            w_first_found_nxt = r_first_found;
        end
    end

    // Scan datapath: window capture, bit-serial run tracking and accumulators.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_shadow      <= 400'd0;
            r_idx         <= 9'd0;
            r_run_len     <= 9'd0;
            r_run_start   <= 9'd0;
            r_first_found <= 1'b0;
            r_first_start <= 9'd0;
            r_first_width <= 9'd0;
            r_count       <= 4'd0;
            r_ones_acc    <= 9'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (tola_en) begin
                        r_shadow      <= total_data;
                        r_idx         <= 9'd0;
                        r_run_len     <= 9'd0;
                        r_run_start   <= 9'd0;
                        r_first_found <= 1'b0;
                        r_first_start <= 9'd0;
                        r_first_width <= 9'd0;
                        r_count       <= 4'd0;
                        r_ones_acc    <= 9'd0;
                    end else begin
                        r_shadow <= r_shadow;
                    end
                end
                S_SCAN: begin
                    // Shift so that the current sample is always in bit 0.
                    r_shadow      <= r_shadow >> 1;
                    r_idx         <= r_idx + 9'd1;
                    r_count       <= w_count_nxt;
                    r_first_start <= w_first_start_nxt;
                    r_first_width <= w_first_width_nxt;
                    r_first_found <= w_first_found_nxt;
                    if (w_bit) begin
                        r_ones_acc <= r_ones_acc + 9'd1;
                        r_run_len  <= r_run_len + 9'd1;
                        if (r_run_len == 9'd0) begin
                            r_run_start <= r_idx;
                        end else begin
                            r_run_start <= r_run_start;
                        end
                    end else begin
                        r_run_len <= 9'd0;
                    end
                end
                S_FINISH: begin
                    r_count       <= w_count_nxt;
                    r_first_start <= w_first_start_nxt;
                    r_first_width <= w_first_width_nxt;
                    r_first_found <= w_first_found_nxt;
                    r_run_len     <= 9'd0;
                end
                default: begin
                    r_run_len <= 9'd0;
                end
            endcase
        end
    end

    // Result and status outputs: results are loaded in FINISH, pulses are one cycle wide.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_result_valid <= 1'b0;
            r_tof_index    <= 9'd0;
            r_pulse_width  <= 9'd0;
            r_echo_count   <= 4'd0;
            r_ones_total   <= 9'd0;
            r_no_echo      <= 1'b0;
            r_overrun      <= 1'b0;
        end else begin
            r_overrun <= tola_en & w_busy;
            if (r_state == S_FINISH) begin
                r_result_valid <= 1'b1;
                r_tof_index    <= w_first_start_nxt;
                r_pulse_width  <= w_first_width_nxt;
                r_echo_count   <= w_count_nxt;
                r_ones_total   <= r_ones_acc;
                r_no_echo      <= (w_count_nxt == 4'd0);
            end else begin
                r_result_valid <= 1'b0;
            end
        end
    end

    assign busy         = w_busy;
    assign result_valid = r_result_valid;
    assign tof_index    = r_tof_index;
    assign pulse_width  = r_pulse_width;
    assign echo_count   = r_echo_count;
    assign ones_total   = r_ones_total;
    assign no_echo      = r_no_echo;
    assign overrun      = r_overrun;

endmodule

// File: tb/tb_echo_tof_extract.sv
// Directed testbench for echo_tof_extract: hand-computed expected results per window.
`timescale 1ns/1ps

module tb_echo_tof_extract;

    logic         clk;
    logic         rst;
    logic [399:0] total_data;
    logic         tola_en;
    logic         busy;
    logic         result_valid;
    logic [8:0]   tof_index;
    logic [8:0]   pulse_width;
    logic [3:0]   echo_count;
    logic [8:0]   ones_total;
    logic         no_echo;
    logic         overrun;

    int n_chk  = 0;
    int n_fail = 0;

    echo_tof_extract #(.MIN_WIDTH(3), .BLANK_BITS(16)) u_dut (
        .clk          (clk),
        .rst          (rst),
        .total_data   (total_data),
        .tola_en      (tola_en),
        .busy         (busy),
        .result_valid (result_valid),
        .tof_index    (tof_index),
        .pulse_width  (pulse_width),
        .echo_count   (echo_count),
        .ones_total   (ones_total),
        .no_echo      (no_echo),
        .overrun      (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Runs one window. Call #1 after a posedge. If started=1, the strobe was
    // already sampled at the preceding edge (E0). Optionally injects a strobe
    // at E0+200 (overrun) and a chained strobe sampled at E0+402.
    task automatic run_win(input string name, input logic started, input logic [399:0] data,
                           input logic [8:0] e_tof, input logic [8:0] e_w,
                           input logic [3:0] e_cnt, input logic [8:0] e_ones,
                           input logic ovr, input logic chain, input logic [399:0] nxt);
        logic early;
        early = 1'b0;
        if (!started) begin
            tola_en    = 1'b1;
            total_data = data;
            @(posedge clk); #1;
            tola_en    = 1'b0;
        end
        chk({name, "_busy"}, busy, 1);
        for (int k = 1; k <= 400; k++) begin
            if (ovr && k == 200) begin
                tola_en    = 1'b1;
                total_data = ~data;
            end
            @(posedge clk); #1;
            if (ovr && k == 200) begin
                chk({name, "_ovr_hi"}, overrun, 1);
                tola_en = 1'b0;
            end
            if (ovr && k == 201) chk({name, "_ovr_lo"}, overrun, 0);
            if (result_valid) early = 1'b1;
        end
        chk({name, "_rv_early"}, early, 0);
        @(posedge clk); #1;
        chk({name, "_rv"}, result_valid, 1);
        chk({name, "_tof"}, tof_index, e_tof);
        chk({name, "_width"}, pulse_width, e_w);
        chk({name, "_count"}, echo_count, e_cnt);
        chk({name, "_ones"}, ones_total, e_ones);
        chk({name, "_noecho"}, no_echo, (e_cnt == 4'd0));
        if (chain) begin
            tola_en    = 1'b1;
            total_data = nxt;
        end
        @(posedge clk); #1;
        tola_en = 1'b0;
        chk({name, "_rv_width"}, result_valid, 0);
        chk({name, "_tof_hold"}, tof_index, e_tof);
    endtask

    logic [399:0] d_a, d_b, d_c, d_d;
    logic seen_rv;

    initial begin
        d_a = '0; d_b = '0; d_c = '0; d_d = '0;
        for (int i = 100; i <= 104; i++) d_a[i] = 1'b1;
        for (int i = 5; i <= 11; i++) d_b[i] = 1'b1;
        d_b[50] = 1'b1; d_b[51] = 1'b1;
        for (int i = 30; i <= 32; i++) d_c[i] = 1'b1;
        for (int i = 200; i <= 212; i++) d_c[i] = 1'b1;
        for (int i = 396; i <= 399; i++) d_c[i] = 1'b1;
        for (int i = 16; i <= 399; i++) d_d[i] = (((i - 16) % 6) < 3);

        // Reset held with a non-zero window and no strobe.
        rst        = 1'b0;
        tola_en    = 1'b0;
        total_data = {400{1'b1}};
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_rv", result_valid, 0);
        chk("rst_tof", tof_index, 0);
        chk("rst_count", echo_count, 0);
        chk("rst_ones", ones_total, 0);
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("idle_busy", busy, 0);
        chk("idle_rv", result_valid, 0);
        chk("idle_ones", ones_total, 0);

        // Single 5-wide pulse at 100.
        run_win("A", 1'b0, d_a, 9'd100, 9'd5, 4'd1, 9'd5, 1'b0, 1'b0, '0);

        // Reset in the middle of a scan, with prior results present.
        tola_en    = 1'b1;
        total_data = d_a;
        @(posedge clk); #1;
        tola_en = 1'b0;
        repeat (50) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("mrst_busy", busy, 0);
        chk("mrst_tof", tof_index, 0);
        chk("mrst_width", pulse_width, 0);
        chk("mrst_ones", ones_total, 0);
        chk("mrst_count", echo_count, 0);
        #2;
        rst = 1'b1;
        seen_rv = 1'b0;
        for (int k = 0; k < 420; k++) begin
            @(posedge clk); #1;
            if (result_valid) seen_rv = 1'b1;
        end
        chk("mrst_no_rv", seen_rv, 0);
        chk("mrst_idle", busy, 0);

        // Blanked pulse plus a too-short pulse.
        run_win("B", 1'b0, d_b, 9'd0, 9'd0, 4'd0, 9'd2, 1'b0, 1'b0, '0);

        // Three pulses, the last reaching bit 399; overrun at E0+200; chained window.
        run_win("C", 1'b0, d_c, 9'd30, 9'd3, 4'd3, 9'd20, 1'b1, 1'b1, d_d);

        // Chained window (accepted at E0+402): 64 triplets, count saturates.
        run_win("D", 1'b1, d_d, 9'd16, 9'd3, 4'd15, 9'd192, 1'b0, 1'b0, '0);

        chk("end_busy", busy, 0);

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
